rom_loader: RTL

// - Boot-time writer for the instruction ROM write port (w_en/w_addr/w_data). Takes a

---
 rtl/rom_loader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// rom_loader: packs a UART byte stream into 32-bit words and writes them
// to the instruction ROM, holding the core in reset until the load is done.
// Params: BASE_ADDR, MAX_WORDS, TIMEOUT_CYCLES.
// Ports: clk, rst (async, active-low); start_i; rx_valid_i/rx_data_i/
//   rx_ready_o byte input; w_en_o/w_addr_o/w_data_o ROM write port;
//   busy_o, done_o, err_o, hold_o status.
// Option: define ROM_LOADER_CHECKSUM_EN for a trailing 32-bit checksum.
`timescale 1ns/1ps
module rom_loader #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned MAX_WORDS      = 4096,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic        rx_ready_o,
   output logic        w_en_o,
   output logic [31:0] w_addr_o,
   output logic [31:0] w_data_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        hold_o
);

   localparam logic [31:0] MAX_W   = MAX_WORDS;
   localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  byte_q, byte_d;
   logic [31:0] pack_q, pack_d;
   logic [31:0] word_q, word_d;
   logic [31:0] n_q, n_d;
   logic [31:0] to_q, to_d;
   logic        w_en_q, w_en_d;
   logic [31:0] w_addr_q, w_addr_d;
   logic [31:0] w_data_q, w_data_d;
`ifdef ROM_LOADER_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;
`endif

   logic        xfer;
   logic        last;
   logic [31:0] asm_w;

   // Bytes shift in from the top so byte 0 ends up in [7:0].
   assign xfer  = rx_valid_i & rx_ready_o;
   assign last  = xfer & (byte_q == 2'd3);
   assign asm_w = {rx_data_i, pack_q[31:8]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         byte_q   <= '0;
         pack_q   <= '0;
         word_q   <= '0;
         n_q      <= '0;
         to_q     <= '0;
         w_en_q   <= 1'b0;
         w_addr_q <= BASE_ADDR;
         w_data_q <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
         sum_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         byte_q   <= byte_d;
         pack_q   <= pack_d;
         word_q   <= word_d;
         n_q      <= n_d;
         to_q     <= to_d;
         w_en_q   <= w_en_d;
         w_addr_q <= w_addr_d;
         w_data_q <= w_data_d;
`ifdef ROM_LOADER_CHECKSUM_EN
         sum_q    <= sum_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      byte_d   = byte_q;
      pack_d   = pack_q;
      word_d   = word_q;
      n_d      = n_q;
      to_d     = to_q;
      w_en_d   = 1'b0;
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_d    = sum_q;
`endif
      if (busy_o) begin
         if (xfer) begin
            pack_d = asm_w;
            byte_d = byte_q + 2'd1;
            to_d   = '0;
         end else begin
            to_d = to_q + 32'd1;
         end
      end
      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start_i) begin
               state_d = S_HDR;
               byte_d  = '0;
               pack_d  = '0;
               word_d  = '0;
               to_d    = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         S_HDR: begin
            if (last) begin
               n_d    = asm_w;
               word_d = '0;
               if (asm_w == 32'd0)
                  state_d = S_DONE;
               else if (asm_w > MAX_W)
                  state_d = S_ERR;
               else
                  state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (last) begin
               w_en_d   = 1'b1;
               w_addr_d = BASE_ADDR + (word_q << 2);
               w_data_d = asm_w;
`ifdef ROM_LOADER_CHECKSUM_EN
               sum_d    = sum_q + asm_w;
`endif
               if (word_q == n_q - 32'd1) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  word_d = word_q + 32'd1;
               end
            end
         end
`ifdef ROM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (last)
               state_d = (asm_w == sum_q) ? S_DONE : S_ERR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
      // Idle gap expired: any half-built word is dropped, nothing written.
      if (busy_o && !xfer && to_q == TO_LAST)
         state_d = S_ERR;
   end

   always_comb begin
      rx_ready_o = 1'b0;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      err_o      = 1'b0;
      hold_o     = 1'b1;
      unique case (state_q)
         S_HDR, S_DATA: begin
            rx_ready_o = 1'b1;
            busy_o     = 1'b1;
         end
`ifdef ROM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            rx_ready_o = 1'b1;
            busy_o     = 1'b1;
         end
`endif
         S_DONE: begin
            done_o = 1'b1;
            hold_o = 1'b0;
         end
         S_ERR: err_o = 1'b1;
         default: ;
      endcase
   end

   assign w_en_o   = w_en_q;
   assign w_addr_o = w_addr_q;
   assign w_data_o = w_data_q;

endmodule
